// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, one bit per cycle.
// Optional MTHI/MTLO write ports: define MULDIV_MTHILO_EN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_e,
  input  logic [1:0]       op_e,
  input  logic [WIDTH-1:0] a_e,
  input  logic [WIDTH-1:0] b_e,
  input  logic             flush_e,
  input  logic             read_hilo_e,
`ifdef MULDIV_MTHILO_EN
  input  logic             mthi_e,
  input  logic             mtlo_e,
  input  logic [WIDTH-1:0] mt_data_e,
`endif
  output logic             stall_e_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb;
  logic                 is_div;
  logic                 sign_q;
  logic                 sign_r;
  logic                 div0;

  logic                 signed_op;
  logic                 accept;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   calc_nxt;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     fix_hi;
  logic [WIDTH-1:0]     fix_lo;

  assign signed_op = ~op_e[0];
  assign accept    = (state == IDLE) & start_e & ~flush_e;
  assign busy_o    = (state != IDLE);

`ifdef MULDIV_MTHILO_EN
  assign stall_e_o = busy_o &
                     (start_e | read_hilo_e | mthi_e | mtlo_e);
`else
  assign stall_e_o = busy_o & (start_e | read_hilo_e);
`endif

  always_comb begin
    a_mag = (signed_op & a_e[WIDTH-1]) ? -a_e : a_e;
    b_mag = (signed_op & b_e[WIDTH-1]) ? -b_e : b_e;
  end

  // MUL: acc = {partial, multiplier}; DIV: acc = {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
               (acc[0] ? {1'b0, opb} : '0);
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
    if (is_div) begin
      if (div_diff[WIDTH])
        calc_nxt = {acc[2*WIDTH-2:0], 1'b0};
      else
        calc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      calc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Divide-by-zero leaves |a| as remainder; sign fix restores raw a.
  always_comb begin
    prod_fix = sign_q ? -acc : acc;
    rem      = acc[2*WIDTH-1:WIDTH];
    quo      = acc[WIDTH-1:0];
    if (is_div) begin
      fix_hi = sign_r ? -rem : rem;
      fix_lo = div0 ? '1 : (sign_q ? -quo : quo);
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      div0   <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            is_div <= op_e[1];
            sign_q <= signed_op & (a_e[WIDTH-1] ^ b_e[WIDTH-1]);
            sign_r <= signed_op & a_e[WIDTH-1];
            div0   <= op_e[1] & (b_e == '0);
            cnt    <= '0;
            state  <= CALC;
            if (op_e[1]) begin
              acc <= {{WIDTH{1'b0}}, a_mag};
              opb <= b_mag;
            end else begin
              acc <= {{WIDTH{1'b0}}, b_mag};
              opb <= a_mag;
            end
          end
`ifdef MULDIV_MTHILO_EN
          else begin
            if (mthi_e & ~flush_e) hi_o <= mt_data_e;
            if (mtlo_e & ~flush_e) lo_o <= mt_data_e;
          end
`endif
        end
        CALC: begin
          acc <= calc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          hi_o   <= fix_hi;
          lo_o   <= fix_lo;
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random ops vs arithmetic reference.
// Covers latency, stall, flush, div-by-zero, overflow and async reset.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_e = 1'b0;
  logic [1:0]    op_e = '0;
  logic [W-1:0]  a_e = '0;
  logic [W-1:0]  b_e = '0;
  logic          flush_e = 1'b0;
  logic          read_hilo_e = 1'b0;
`ifdef MULDIV_MTHILO_EN
  logic          mthi_e = 1'b0;
  logic          mtlo_e = 1'b0;
  logic [W-1:0]  mt_data_e = '0;
`endif
  logic          stall_e_o;
  logic          busy_o;
  logic          done_o;
  logic [W-1:0]  hi_o;
  logic [W-1:0]  lo_o;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_e     (start_e),
    .op_e        (op_e),
    .a_e         (a_e),
    .b_e         (b_e),
    .flush_e     (flush_e),
    .read_hilo_e (read_hilo_e),
`ifdef MULDIV_MTHILO_EN
    .mthi_e      (mthi_e),
    .mtlo_e      (mtlo_e),
    .mt_data_e   (mt_data_e),
`endif
    .stall_e_o   (stall_e_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint       sp;
    logic [63:0]  up;
    int           q;
    int           r;
    case (op)
      MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        return up;
      end
      DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = 32'd1;
      2: v = '1;
      3: v = 32'h8000_0000;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // Holds start_e until the unit is idle; each waiting cycle must stall.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int   n;
    exp_t e;
    logic [63:0] r;
    n = 0;
    op_e = op;
    a_e = a;
    b_e = b;
    start_e = 1'b1;
    while (busy_o && n < 200) begin
      #1 chk("stall_on_start", {63'b0, stall_e_o}, 64'd1);
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("issue_timeout", {63'b0, busy_o}, 64'd0);
    end else begin
      #1 chk("no_stall_idle", {63'b0, stall_e_o}, 64'd0);
      r = ref_model(op, a, b);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.acc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      chk("busy_after_accept", {63'b0, busy_o}, 64'd1);
    end
    start_e = 1'b0;
    a_e = $urandom();
    b_e = $urandom();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (done_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {63'b0, done_o}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("hi", hi_o, e.hi);
          chk("lo", lo_o, e.lo);
          chk("latency", cyc, e.acc + W + 1);
          mhi = e.hi;
          mlo = e.lo;
        end
      end else if (busy_o) begin
        chk("hilo_hold", {hi_o, lo_o}, {mhi, mlo});
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'b0, busy_o}, 64'd0);
    chk("rst_done", {63'b0, done_o}, 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // start with flush in IDLE must not launch; no stall when idle
    op_e = MULT;
    a_e = 32'd3;
    b_e = 32'd4;
    start_e = 1'b1;
    flush_e = 1'b1;
    read_hilo_e = 1'b1;
    #1 chk("idle_stall", {63'b0, stall_e_o}, 64'd0);
    @(negedge clk);
    chk("flush_no_start", {63'b0, busy_o}, 64'd0);
    start_e = 1'b0;
    flush_e = 1'b0;
    read_hilo_e = 1'b0;

    issue(MULT, 32'hFFFF_FFFD, 32'd5);
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    chk("multu_dir", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);

    issue(DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    read_hilo_e = 1'b1;
    #1 chk("stall_on_read", {63'b0, stall_e_o}, 64'd1);
    @(negedge clk);
    read_hilo_e = 1'b0;
    flush_e = 1'b1;
    repeat (3) @(negedge clk);
    flush_e = 1'b0;
    drain();
    chk("divu_dir", {hi_o, lo_o}, {32'd2, 32'd14});

    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    drain();
    chk("div_neg", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(DIV, 32'd1234, 32'd0);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(DIVU, 32'h8000_0000, 32'd0);
    drain();

    repeat (24) begin
      issue(2'($urandom_range(0, 3)), pick(), pick());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // async reset in the middle of an operation
    issue(MULT, 32'hFFFF_FFFD, 32'd5);
    drain();
    issue(MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", {63'b0, busy_o}, 64'd0);
    chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
    chk("midrst_done", {63'b0, done_o}, 64'd0);
    sb.delete();
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 5) @(negedge clk);
    chk("post_rst_hilo", {hi_o, lo_o}, 64'd0);

`ifdef MULDIV_MTHILO_EN
    mthi_e = 1'b1;
    mt_data_e = 32'hDEAD_BEEF;
    @(negedge clk);
    mthi_e = 1'b0;
    chk("mthi", hi_o, 32'hDEAD_BEEF);
    mhi = 32'hDEAD_BEEF;
    mtlo_e = 1'b1;
    mt_data_e = 32'h0BAD_F00D;
    @(negedge clk);
    mtlo_e = 1'b0;
    chk("mtlo", lo_o, 32'h0BAD_F00D);
    mlo = 32'h0BAD_F00D;
`endif

    issue(DIVU, 32'd100, 32'd7);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
